// File: rtl/decrypt_message.sv
`default_nettype none
// decrypt_message: RC4 keystream generator over the key-scheduled S RAM. It XORs each keystream
// byte with the encrypted ROM, writes the plaintext to RAM and flags lowercase/space messages. Rev 1.0
module decrypt_message #(
  parameter  int MSG_LEN = 32,
  localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          finish,
  output logic          msg_valid,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    s_q,
  output logic [AW-1:0] rom_address,
  input  logic [7:0]    rom_q,
  output logic [AW-1:0] ram_address,
  output logic [7:0]    ram_data,
  output logic          ram_wren
);

  localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INC_I    = 4'd1,
    RD_SI    = 4'd2,
    WAIT_SI  = 4'd3,
    LATCH_SI = 4'd4,
    RD_SJ    = 4'd5,
    WAIT_SJ  = 4'd6,
    LATCH_SJ = 4'd7,
    WR_SI    = 4'd8,
    WR_SJ    = 4'd9,
    RD_F     = 4'd10,
    WAIT_F   = 4'd11,
    LATCH_F  = 4'd12,
    WR_OUT   = 4'd13,
    CHECK    = 4'd14,
    DONE     = 4'd15
  } state_t;

  state_t        state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [7:0]    f_x;
  logic [AW-1:0] k;
  logic          char_ok;

  assign char_ok = ((f_x >= 8'h61) && (f_x <= 8'h7A)) || (f_x == 8'h20);

  // Every memory read is RD -> WAIT -> LATCH because the RAM/ROM register their address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      i           <= 8'd0;
      j           <= 8'd0;
      k           <= '0;
      si          <= 8'd0;
      sj          <= 8'd0;
      f_x         <= 8'd0;
      finish      <= 1'b0;
      msg_valid   <= 1'b0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      ram_address <= '0;
      ram_data    <= 8'd0;
      ram_wren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= '0;
            state <= INC_I;
          end
        end
        INC_I: begin
          i     <= i + 8'd1;
          state <= RD_SI;
        end
        RD_SI: begin
          s_address <= i;
          state     <= WAIT_SI;
        end
        WAIT_SI: state <= LATCH_SI;
        LATCH_SI: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= RD_SJ;
        end
        RD_SJ: begin
          s_address <= j;
          state     <= WAIT_SJ;
        end
        WAIT_SJ: state <= LATCH_SJ;
        LATCH_SJ: begin
          sj    <= s_q;
          state <= WR_SI;
        end
        // When i == j the second write lands on the same word with the same value.
        WR_SI: begin
          s_address <= i;
          s_data    <= sj;
          s_wren    <= 1'b1;
          state     <= WR_SJ;
        end
        WR_SJ: begin
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= RD_F;
        end
        RD_F: begin
          s_wren      <= 1'b0;
          s_address   <= si + sj;
          rom_address <= k;
          state       <= WAIT_F;
        end
        WAIT_F: state <= LATCH_F;
        LATCH_F: begin
          f_x   <= s_q ^ rom_q;
          state <= WR_OUT;
        end
        WR_OUT: begin
          ram_address <= k;
          ram_data    <= f_x;
          ram_wren    <= 1'b1;
          state       <= CHECK;
        end
        CHECK: begin
          ram_wren <= 1'b0;
          if (!char_ok) begin
            msg_valid <= 1'b0;
            finish    <= 1'b1;
            state     <= DONE;
          end else if (k == LAST) begin
            msg_valid <= 1'b1;
            finish    <= 1'b1;
            state     <= DONE;
          end else begin
            k     <= k + AW'(1);
            state <= INC_I;
          end
        end
        DONE: begin
          if (!start) begin
            finish    <= 1'b0;
            msg_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_message.sv
`default_nettype none
// tb_decrypt_message: table-driven and randomized checks of decrypt_message against a software RC4 model.
module tb_decrypt_message;

  localparam int MSG_LEN = 32;
  localparam int AW      = 5;
  localparam int BOUND   = 2000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          finish;
  logic          msg_valid;
  logic [7:0]    s_address;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] rom_address;
  logic [7:0]    rom_q;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data;
  logic          ram_wren;

  always #5 clk = ~clk;

  decrypt_message #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish), .msg_valid(msg_valid),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren)
  );

  // Memory models with registered read address
  logic [7:0]    s_mem   [256];
  logic [7:0]    s_init  [256];
  logic [7:0]    enc     [MSG_LEN];
  logic [7:0]    out_mem [MSG_LEN];
  int            out_cnt [MSG_LEN];
  logic [7:0]    s_areg;
  logic [AW-1:0] rom_areg;
  logic          load;
  int            s_wr_cycles, ram_wr_cycles, done_wr_cycles;

  assign s_q   = s_mem[s_areg];
  assign rom_q = enc[rom_areg];

  always @(posedge clk) begin
    s_areg   <= s_address;
    rom_areg <= rom_address;
    if (load) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
      for (int x = 0; x < MSG_LEN; x++) begin
        out_mem[x] <= 8'hEE;
        out_cnt[x] <= 0;
      end
      s_wr_cycles    <= 0;
      ram_wr_cycles  <= 0;
      done_wr_cycles <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_address] <= s_data;
        s_wr_cycles      <= s_wr_cycles + 1;
      end
      if (ram_wren) begin
        out_mem[ram_address] <= ram_data;
        out_cnt[ram_address] <= out_cnt[ram_address] + 1;
        ram_wr_cycles        <= ram_wr_cycles + 1;
      end
      if (finish && (s_wren || ram_wren)) done_wr_cycles <= done_wr_cycles + 1;
    end
  end

  // Reference model
  logic [7:0] m_s   [256];
  logic [7:0] m_out [MSG_LEN];
  logic [7:0] m_ks  [MSG_LEN];
  int         m_n;
  logic       m_valid;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic ok_char(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic model_run(input logic no_abort);
    logic [7:0] mi, mj, msi, msj, t;
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    mi = 8'd0; mj = 8'd0; m_n = 0; m_valid = 1'b1;
    for (int q = 0; q < MSG_LEN; q++) begin
      mi = mi + 8'd1;
      msi = m_s[mi];
      mj = mj + msi;
      msj = m_s[mj];
      m_s[mi] = msj;
      m_s[mj] = msi;
      t = msi + msj;
      m_ks[q]  = m_s[t];
      m_out[q] = m_ks[q] ^ enc[q];
      if (!no_abort) begin
        m_n++;
        if (!ok_char(m_out[q])) begin
          m_valid = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic ksa(input logic [23:0] key);
    logic [7:0] kj, t, kb;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    kj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      kb = (x % 3 == 0) ? key[23:16] : (x % 3 == 1) ? key[15:8] : key[7:0];
      kj = kj + s_init[x] + kb;
      t = s_init[x];
      s_init[x] = s_init[kj];
      s_init[kj] = t;
    end
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic snapshot_s();
    for (int x = 0; x < 256; x++) s_init[x] = s_mem[x];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic load_mem();
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Runs one decryption from the S contents in s_init; drops start one edge after finish unless held.
  task automatic do_run(input string tag, input int toggle_at, input int hold_after,
                        output int edges, output logic fin_valid);
    logic seen;
    int   mis, smis;
    model_run(1'b0);
    load_mem();
    start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (edges < BOUND && !seen) begin
      @(posedge clk);
      edges++;
      #1;
      if (finish) seen = 1'b1;
      else start = (edges == toggle_at) ? 1'b0 : 1'b1;
    end
    fin_valid = msg_valid;
    chk({tag, " finish_edge"}, 64'(edges), 64'(1 + 14 * m_n));
    chk({tag, " msg_valid"}, 64'(msg_valid), 64'(m_valid));
    mis = 0;
    for (int q = 0; q < MSG_LEN; q++) begin
      if (q < m_n) begin
        if (out_mem[q] !== m_out[q] || out_cnt[q] != 1) mis++;
      end else if (out_mem[q] !== 8'hEE || out_cnt[q] != 0) mis++;
    end
    chk({tag, " ram_bytes_mismatched"}, 64'(mis), 64'd0);
    smis = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) smis++;
    chk({tag, " s_bytes_mismatched"}, 64'(smis), 64'd0);
    for (int h = 0; h < hold_after; h++) begin
      @(posedge clk);
      #1 chk({tag, " hold_finish_valid"}, 64'({finish, msg_valid}), 64'({1'b1, m_valid}));
    end
    start = 1'b0;
    @(posedge clk);
    #1 chk({tag, " finish_clear"}, 64'({finish, msg_valid}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " s_wren_cycles"}, 64'(s_wr_cycles), 64'(2 * m_n));
    chk({tag, " ram_wren_cycles"}, 64'(ram_wr_cycles), 64'(m_n));
    chk({tag, " wren_in_done"}, 64'(done_wr_cycles), 64'd0);
  endtask

  typedef struct {
    logic [7:0] enc0;
    logic [7:0] enc1;
    logic [7:0] fill;
    logic [7:0] ram0;
    logic [7:0] ram1;
    logic       valid;
    int         edges;
  } vec_t;

  vec_t vt[9];

  // Identity S gives keystream bytes 0x02, 0x05 for the first two positions.
  task automatic set_enc_identity(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] fill);
    identity_s();
    model_run(1'b1);
    for (int q = 0; q < MSG_LEN; q++) enc[q] = m_ks[q] ^ fill;
    enc[0] = e0;
    enc[1] = e1;
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   edges;
    logic fv;
    logic [23:0] key;
    int   pos;

    vt[0] = '{8'h63, 8'h64, 8'h7A, 8'h61, 8'h61, 1'b1, 449};
    vt[1] = '{8'h02, 8'h64, 8'h7A, 8'h00, 8'hEE, 1'b0, 15};
    vt[2] = '{8'h22, 8'h25, 8'h7B, 8'h20, 8'h20, 1'b0, 43};
    vt[3] = '{8'h63, 8'h07, 8'h7A, 8'h61, 8'h02, 1'b0, 29};
    vt[4] = '{8'h7C, 8'h64, 8'h7A, 8'h7E, 8'hEE, 1'b0, 15};
    vt[5] = '{8'h78, 8'h65, 8'h7A, 8'h7A, 8'h60, 1'b0, 29};
    vt[6] = '{8'h79, 8'h64, 8'h7A, 8'h7B, 8'hEE, 1'b0, 15};
    vt[7] = '{8'h23, 8'h64, 8'h7A, 8'h21, 8'hEE, 1'b0, 15};
    vt[8] = '{8'h22, 8'h25, 8'h20, 8'h20, 8'h20, 1'b1, 449};

    reset_n = 1'b0;
    start   = 1'b0;
    load    = 1'b0;
    identity_s();
    for (int q = 0; q < MSG_LEN; q++) enc[q] = 8'h00;
    #2;
    chk("reset_outputs", 64'({finish, msg_valid, s_address, s_data, s_wren, rom_address,
                              ram_address, ram_data, ram_wren}), 64'd0);
    load_mem();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      set_enc_identity(vt[v].enc0, vt[v].enc1, vt[v].fill);
      do_run($sformatf("vec%0d", v), -1, 0, edges, fv);
      chk($sformatf("vec%0d ram0", v), 64'(out_mem[0]), 64'(vt[v].ram0));
      chk($sformatf("vec%0d ram1", v), 64'(out_mem[1]), 64'(vt[v].ram1));
      chk($sformatf("vec%0d valid", v), 64'(fv), 64'(vt[v].valid));
      chk($sformatf("vec%0d edges", v), 64'(edges), 64'(vt[v].edges));
      if (vt[v].edges == 29)
        chk($sformatf("vec%0d s2_s3_swap", v), 64'({s_mem[2], s_mem[3]}), 64'({8'd3, 8'd2}));
    end

    // Key 000249 with random ROM, then with a valid plaintext
    ksa(24'h000249);
    for (int q = 0; q < MSG_LEN; q++) enc[q] = 8'($urandom);
    do_run("key249_rand", -1, 0, edges, fv);
    ksa(24'h000249);
    model_run(1'b1);
    for (int q = 0; q < MSG_LEN; q++) enc[q] = m_ks[q] ^ rand_char();
    do_run("key249_valid", -1, 0, edges, fv);
    chk("key249_valid full", 64'(fv), 64'd1);

    for (int r = 0; r < 6; r++) begin
      key = 24'($urandom);
      ksa(key);
      model_run(1'b1);
      for (int q = 0; q < MSG_LEN; q++) enc[q] = m_ks[q] ^ rand_char();
      if (r[0]) begin
        pos = $urandom_range(0, MSG_LEN - 1);
        enc[pos] = m_ks[pos] ^ (8'h80 | 8'($urandom));
      end
      do_run($sformatf("rand%0d", r), -1, 0, edges, fv);
    end

    // Start dropped mid-run has no effect
    set_enc_identity(8'h63, 8'h64, 8'h7A);
    do_run("toggle", 50, 0, edges, fv);
    chk("toggle edges", 64'(edges), 64'd449);

    // Start held after finish, then a rerun from the resulting S
    set_enc_identity(8'h63, 8'h64, 8'h7A);
    do_run("hold", -1, 10, edges, fv);
    snapshot_s();
    do_run("rerun", -1, 0, edges, fv);

    // Asynchronous reset mid-run, then restart
    set_enc_identity(8'h63, 8'h64, 8'h7A);
    load_mem();
    start = 1'b1;
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("midrun_reset_outputs", 64'({finish, msg_valid, s_address, s_data, s_wren, rom_address,
                                        ram_address, ram_data, ram_wren}), 64'd0);
    start = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    snapshot_s();
    do_run("after_reset", -1, 0, edges, fv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decrypt_message.md
# decrypt_message

RC4 keystream generator and decryptor: the consumer of the key-scheduled S array. It starts after the shuffle stage has finished writing S. It reads and swaps S (PRGA), XORs each keystream byte with the encrypted message ROM, and writes plaintext to the decrypted-message RAM. It flags whether every output byte is lowercase ASCII or space, so the brute-force controller can accept or reject the current key.

## Interface
- MSG_LEN, 32: message length in bytes (1..256).
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; held high by controller until finish seen.
- finish  out  1  high in DONE only.
- msg_valid  out  1  qualifies finish: 1 = all MSG_LEN bytes valid.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data.
- rom_address  out  $clog2(MSG_LEN)  encrypted ROM address (k).
- rom_q  in  8  encrypted byte.
- ram_address  out  $clog2(MSG_LEN)  plaintext RAM address.
- ram_data  out  8  plaintext byte.
- ram_wren  out  1  plaintext RAM write enable.

## Operation
- All outputs are registered. On reset_n=0, every output goes to 0, i/j/k/si/sj/f go to 0, and state goes to IDLE, immediately (async).
- Per byte k = 0..MSG_LEN-1: i=i+1; si=S[i]; j=j+si; sj=S[j]; S[i]=sj; S[j]=si; f=S[si+sj]; out[k]=f^enc[k].
- All index arithmetic is 8-bit and wraps mod 256; no carry kept.
- States, one cycle each:
  - IDLE: if start, clear i/j/k, go INC_I.
  - INC_I: i<=i+1.
  - RD_SI: s_address<=i. Then WAIT_SI.
  - LATCH_SI: si<=s_q; j<=j+s_q.
  - RD_SJ: s_address<=j. Then WAIT_SJ.
  - LATCH_SJ: sj<=s_q.
  - WR_SI: s_address<=i, s_data<=sj, s_wren<=1.
  - WR_SJ: s_address<=j, s_data<=si, s_wren<=1.
  - RD_F: s_wren<=0, s_address<=si+sj, rom_address<=k. Then WAIT_F.
  - LATCH_F: f_x<=s_q^rom_q.
  - WR_OUT: ram_address<=k, ram_data<=f_x, ram_wren<=1.
  - CHECK: ram_wren<=0.
    - If the byte is not 8'h61..8'h7A and not 8'h20: msg_valid<=0, finish<=1, go DONE (early abort).
    - Else if k==MSG_LEN-1: msg_valid<=1, finish<=1, go DONE.
    - Else k<=k+1, go INC_I.
  - DONE: hold finish/msg_valid while start=1. When start=0: clear both, go IDLE.
- i==j: WR_SJ overwrites WR_SI at the same address with si (==sj), giving a correct result.
- start deasserted outside IDLE/DONE is ignored. The operation runs to completion.
- start already low in DONE: finish is high for exactly one cycle.

## Timing
- Memory model: the RAM/ROM registers the address. q is valid for sampling two edges after the edge that updates the address (RD -> WAIT -> LATCH).
- A write occurs on the edge after the cycle in which address, data and wren are presented together.
- 14 cycles per byte. finish rises 1+14*MSG_LEN edges after the first edge sampling start=1 in IDLE (449 for MSG_LEN=32).
- Early abort at byte k: finish rises 1+14*(k+1) edges after start; the invalid byte is still written to RAM.
- s_wren is high for exactly 2 cycles per byte; ram_wren is high for exactly 1.
- s_wren and ram_wren are never high in IDLE or DONE.

## Test plan
- Identity S (S[x]=x), enc[0]=8'h63, enc[1]=8'h64, rest chosen valid, MSG_LEN=32 -> ram[0]=8'h61, ram[1]=8'h61. After byte 1: S[2]=3, S[3]=2. msg_valid=1; finish at edge 449.
- Identity S, enc[0]=8'h02 -> ram[0]=8'h00 written once; finish at edge 15 with msg_valid=0; no writes to ram[1].
- Key-scheduled S from key 24'h000249 plus a random enc ROM -> ram and final S match a software RC4 model byte-for-byte. msg_valid matches the model's charset check.
- reset_n pulsed low at edge 100 -> all outputs 0 asynchronously. Restart with start completes with normal latency and results.
- start held high 10 cycles after finish, then dropped -> finish/msg_valid stay high until the edge after start=0, then 0. A second start reruns correctly from IDLE.
- Toggle start low mid-run (edge 50) -> no effect; finish still at edge 449.
